// File: rtl/fetch_redirect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect_pkg
// Description : Shared types and constants for the fetch/redirect front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_redirect_pkg;

    typedef logic [31:0] addr;
    typedef logic [31:0] instr;

    // Entry delivered downstream: fetched word tagged with its PC.
    typedef struct packed {
        addr  pc;
        instr ins;
    } fetch_entry;

    // Outstanding memory request; killed marks a wrong-path fetch.
    typedef struct packed {
        addr  pc;
        logic killed;
    } pending_entry;

    localparam addr c_reset_pc = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Synchronous FIFO generic in entry type and depth, with a
//               clear input and a per-entry kill bit that mark_all sets on
//               every stored entry (and on an entry pushed the same cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         push_kill,
    input  logic                         pop,
    input  logic                         mark_all,
    output T                             head_data,
    output logic                         head_kill,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T                r_mem [DEPTH];
    logic [DEPTH-1:0] r_kill;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;
    logic [AW-1:0]   w_wptr_nxt;
    logic [AW-1:0]   w_rptr_nxt;

    // A full FIFO can still take a push when the head leaves the same cycle.
    assign w_do_pop   = pop && (r_count != '0);
    assign w_do_push  = push && ((r_count != CW'(DEPTH)) || w_do_pop);
    assign w_wptr_nxt = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    // Entry storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Kill bits: mark_all kills everything held, including this cycle's push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill <= '0;
        end else begin
            if (mark_all) begin
                r_kill <= '1;
            end
            if (w_do_push) begin
                r_kill[r_wptr] <= push_kill | mark_all;
            end
        end
    end

    // Pointers and occupancy; clear empties the FIFO and overrides push/pop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_do_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rptr];
    assign head_kill = r_kill[r_rptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect
// Description : PC generator and in-order instruction fetcher. Accepts taken
//               branch redirects, kills wrong-path fetches in flight and
//               delivers {pc, instr} entries on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter addr RESET_PC     = c_reset_pc,
    parameter int  MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        flush
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int IW = CW + 1;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    logic [1:0]   r_state;
    addr          r_pc;
    logic         r_flush;

    pending_entry w_pend_push;
    pending_entry w_pend_head;
    addr          w_pend_head_pc;
    logic         w_pend_head_kill;
    logic [CW-1:0] w_pend_cnt;

    fetch_entry   w_out_push;
    fetch_entry   w_out_head;
    logic         w_out_head_kill;
    logic [CW-1:0] w_out_cnt;

    logic [IW-1:0] w_inflight;
    logic          w_has_credit;
    logic          w_req_fire;
    logic          w_resp_fire;
    logic          w_out_push_en;
    logic          w_out_fire;

    // Credits cover both outstanding requests and buffered results, so every
    // response is guaranteed a slot in the output FIFO.
    assign w_inflight   = IW'(w_pend_cnt) + IW'(w_out_cnt);
    assign w_has_credit = w_inflight < IW'(MAX_INFLIGHT);

    assign req_valid  = (r_state == S_RUN) && w_has_credit;
    assign req_addr   = req_valid ? r_pc : '0;
    assign w_req_fire = req_valid && req_ready;

    // A request accepted in the redirect cycle is already wrong-path.
    assign w_pend_push = '{pc: r_pc, killed: br_valid};
    assign w_pend_head = '{pc: w_pend_head_pc, killed: w_pend_head_kill};

    // Responses with nothing pending are ignored.
    assign w_resp_fire   = resp_valid && (w_pend_cnt != '0);
    assign w_out_push_en = w_resp_fire && !w_pend_head.killed && !br_valid;
    assign w_out_push    = '{pc: w_pend_head.pc, ins: resp_data};

    assign out_valid  = (w_out_cnt != '0) && !w_out_head_kill;
    assign w_out_fire = out_valid && out_ready;
    assign out_pc     = out_valid ? w_out_head.pc  : '0;
    assign out_instr  = out_valid ? w_out_head.ins : '0;
    assign flush      = r_flush;

    sync_fifo #(
        .T     (addr),
        .DEPTH (MAX_INFLIGHT)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (w_req_fire),
        .push_data (w_pend_push.pc),
        .push_kill (w_pend_push.killed),
        .pop       (w_resp_fire),
        .mark_all  (br_valid),
        .head_data (w_pend_head_pc),
        .head_kill (w_pend_head_kill),
        .count     (w_pend_cnt)
    );

    sync_fifo #(
        .T     (fetch_entry),
        .DEPTH (MAX_INFLIGHT)
    ) u_output (
        .clk       (clk),
        .rst       (rst),
        .clear     (br_valid),
        .push      (w_out_push_en),
        .push_data (w_out_push),
        .push_kill (1'b0),
        .pop       (w_out_fire),
        .mark_all  (1'b0),
        .head_data (w_out_head),
        .head_kill (w_out_head_kill),
        .count     (w_out_cnt)
    );

    // FSM, PC and flush: a redirect wins over the sequential pc+4 advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
        end else begin
            r_flush <= br_valid;
            if (br_valid) begin
                r_state <= S_REDIR;
                r_pc    <= br_target & ~32'd3;
            end else begin
                case (r_state)
                    S_BOOT:  r_state <= S_RUN;
                    S_RUN:   r_state <= S_RUN;
                    S_REDIR: r_state <= S_RUN;
                    default: r_state <= S_RUN;
                endcase
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
            end
        end
    end

    // Memory must never answer a request that was not issued.
    a_resp_has_pending: assert property (
        @(posedge clk) disable iff (rst) resp_valid |-> (w_pend_cnt != '0)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_redirect
// Description : Randomised and directed self-checking bench for
//               fetch_redirect against an epoch-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect;

    localparam int          MAX    = 2;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;

    always #5 clk = ~clk;

    fetch_redirect #(.RESET_PC(RST_PC), .MAX_INFLIGHT(MAX)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_target(br_target),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .flush(flush)
    );

    // Reference model: requests carry the redirect epoch they were issued in;
    // a result is delivered only if no redirect happened since.
    typedef struct { logic [31:0] pc; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    mreq_t       mem_q[$];
    ent_t        exp_out[$];
    logic [31:0] exp_pc;
    int          epoch;
    bit          booted, redir, exp_flush;
    int          cyc = 0;
    int          lat_max = 0;
    int          vectors = 0;
    int          miscompares = 0;

    bit          tb_rst = 1'b1, tb_br = 1'b0, tb_req_ready = 1'b0;
    bit          tb_out_ready = 1'b0, tb_mem_hold = 1'b0;
    logic [31:0] tb_target = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit exp_req_valid();
        return booted && !redir && ((mem_q.size() + exp_out.size()) < MAX);
    endfunction

    task automatic model_reset();
        mem_q.delete();
        exp_out.delete();
        exp_pc = RST_PC; epoch = 0; booted = 0; redir = 0; exp_flush = 0;
    endtask

    // Apply this cycle's inputs on the falling edge, then settle.
    task automatic drive();
        @(negedge clk);
        rst = tb_rst; br_valid = tb_br; br_target = tb_target;
        req_ready = tb_req_ready; out_ready = tb_out_ready;
        if (!tb_rst && !tb_mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            resp_valid = 1'b1; resp_data = mem_word(mem_q[0].pc);
        end else begin
            resp_valid = 1'b0; resp_data = $urandom;
        end
        #1;
    endtask

    // Advance the reference model across the rising edge.
    task automatic commit();
        bit    hs, resp;
        mreq_t m;
        hs   = exp_req_valid() && tb_req_ready;
        resp = resp_valid;
        @(posedge clk);
        if (tb_rst) begin model_reset(); cyc++; return; end
        if (exp_out.size() > 0 && tb_out_ready) void'(exp_out.pop_front());
        if (tb_br) exp_out.delete();
        if (resp) begin
            m = mem_q.pop_front();
            if (m.epoch == epoch && !tb_br) exp_out.push_back('{pc: m.pc, ins: mem_word(m.pc)});
        end
        if (hs) mem_q.push_back('{pc: exp_pc, epoch: epoch, due: cyc + 1 + int'($urandom_range(0, lat_max))});
        if (tb_br) begin epoch++; exp_pc = tb_target & ~32'd3; end
        else if (hs) exp_pc = exp_pc + 32'd4;
        exp_flush = tb_br; redir = tb_br; booted = 1; cyc++;
    endtask

    task automatic do_reset();
        tb_rst = 1; tb_br = 0; tb_mem_hold = 0;
        drive(); commit();
        tb_rst = 0;
    endtask

    task automatic test_reset();
        tb_rst = 1; tb_br = 0; tb_req_ready = 1; tb_out_ready = 1; tb_mem_hold = 0; lat_max = 0;
        drive(); commit();
        drive();
        vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got=%b want=0", req_valid); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush got=%b want=0", flush); end
        vectors++; if (req_addr !== 32'h0) begin miscompares++; $display("FAIL reset_req_addr got=%h want=0", req_addr); end
        vectors++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out got=%h/%h want=0/0", out_pc, out_instr); end
        commit();
        tb_rst = 0;
        drive();
        vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL boot_req_valid got=%b want=0", req_valid); end
        commit();
        drive();
        vectors++; if (req_valid !== 1'b1 || req_addr !== RST_PC) begin miscompares++; $display("FAIL first_req got=%b/%h want=1/%h", req_valid, req_addr, RST_PC); end
        commit();
    endtask

    task automatic test_stream();
        logic [31:0] acc[$];
        logic [31:0] want_addr, want_pc, want_in;
        bit          want_ov;
        tb_req_ready = 1; tb_out_ready = 1; lat_max = 0; tb_br = 0;
        for (int i = 0; i < 24; i++) begin
            drive();
            if (req_valid && req_ready) acc.push_back(req_addr);
            want_addr = exp_req_valid() ? exp_pc : 32'h0;
            want_ov   = exp_out.size() > 0;
            want_pc   = want_ov ? exp_out[0].pc  : 32'h0;
            want_in   = want_ov ? exp_out[0].ins : 32'h0;
            vectors++; if (req_valid !== exp_req_valid()) begin miscompares++; $display("FAIL stream_req_valid cyc=%0d got=%b want=%b", cyc, req_valid, exp_req_valid()); end
            vectors++; if (req_addr !== want_addr) begin miscompares++; $display("FAIL stream_req_addr cyc=%0d got=%h want=%h", cyc, req_addr, want_addr); end
            vectors++; if (out_valid !== want_ov) begin miscompares++; $display("FAIL stream_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, want_ov); end
            vectors++; if (out_pc !== want_pc || out_instr !== want_in) begin miscompares++; $display("FAIL stream_out cyc=%0d got=%h/%h want=%h/%h", cyc, out_pc, out_instr, want_pc, want_in); end
            vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL stream_flush cyc=%0d got=%b want=0", cyc, flush); end
            commit();
        end
        vectors++; if (acc.size() < 4) begin miscompares++; $display("FAIL stream_count got=%0d want>=4", acc.size()); end
        foreach (acc[i]) begin
            vectors++;
            if (acc[i] !== 32'h8000_0004 + 32'(4 * i)) begin miscompares++; $display("FAIL stream_seq i=%0d got=%h want=%h", i, acc[i], 32'h8000_0004 + 32'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] acc[$];
        logic [31:0] first_req;
        do_reset();
        tb_req_ready = 1; tb_out_ready = 0; lat_max = 0;
        for (int i = 0; i < 12; i++) begin
            drive();
            if (req_valid && req_ready) acc.push_back(req_addr);
            commit();
        end
        vectors++; if (acc.size() != 2) begin miscompares++; $display("FAIL bp_req_count got=%0d want=2", acc.size()); end
        if (acc.size() >= 2) begin
            vectors++; if (acc[0] !== 32'h8000_0000 || acc[1] !== 32'h8000_0004) begin miscompares++; $display("FAIL bp_req_addrs got=%h,%h want=80000000,80000004", acc[0], acc[1]); end
        end
        drive();
        vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_stalled got=%b want=0", req_valid); end
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_instr !== mem_word(32'h8000_0000)) begin miscompares++; $display("FAIL bp_head got=%b/%h/%h want=1/80000000/%h", out_valid, out_pc, out_instr, mem_word(32'h8000_0000)); end
        commit();
        tb_out_ready = 1;
        first_req = 32'hDEAD_BEEF;
        for (int i = 0; i < 6 && first_req === 32'hDEAD_BEEF; i++) begin
            drive();
            if (req_valid) first_req = req_addr;
            commit();
        end
        vectors++; if (first_req !== 32'h8000_0008) begin miscompares++; $display("FAIL bp_resume got=%h want=80000008", first_req); end
    endtask

    task automatic test_redirect_pending();
        logic [31:0] first_req, first_out, first_ins;
        do_reset();
        tb_req_ready = 1; tb_out_ready = 1; lat_max = 0; tb_mem_hold = 1;
        for (int i = 0; i < 8 && mem_q.size() < 2; i++) begin drive(); commit(); end
        vectors++; if (mem_q.size() != 2) begin miscompares++; $display("FAIL redir_setup pending got=%0d want=2", mem_q.size()); end
        tb_br = 1; tb_target = 32'h8000_1003;
        drive(); commit();
        tb_br = 0; tb_mem_hold = 0;
        drive();
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL redir_flush got=%b want=1", flush); end
        vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_req_off got=%b want=0", req_valid); end
        commit();
        first_req = 32'hDEAD_BEEF; first_out = 32'hDEAD_BEEF; first_ins = 32'h0;
        for (int i = 0; i < 12; i++) begin
            drive();
            if (req_valid && first_req === 32'hDEAD_BEEF) first_req = req_addr;
            if (out_valid && first_out === 32'hDEAD_BEEF) begin first_out = out_pc; first_ins = out_instr; end
            vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL redir_flush_once got=%b want=0", flush); end
            commit();
        end
        vectors++; if (first_req !== 32'h8000_1000) begin miscompares++; $display("FAIL redir_req_addr got=%h want=80001000", first_req); end
        vectors++; if (first_out !== 32'h8000_1000 || first_ins !== mem_word(32'h8000_1000)) begin miscompares++; $display("FAIL redir_first_out got=%h/%h want=80001000/%h", first_out, first_ins, mem_word(32'h8000_1000)); end
    endtask

    task automatic test_coincident();
        bit          fired;
        logic [31:0] first_req, first_out;
        do_reset();
        tb_req_ready = 1; tb_out_ready = 1; lat_max = 0;
        fired = 0;
        for (int i = 0; i < 10 && !fired; i++) begin
            if (exp_req_valid() && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                tb_br = 1; tb_target = 32'h8000_2000; fired = 1;
            end
            drive();
            if (fired) begin
                vectors++; if (req_valid !== 1'b1 || resp_valid !== 1'b1) begin miscompares++; $display("FAIL coin_overlap req_valid=%b resp_valid=%b want=1/1", req_valid, resp_valid); end
            end
            commit();
            tb_br = 0;
        end
        vectors++; if (!fired) begin miscompares++; $display("FAIL coin_setup got=0 want=1"); end
        first_req = 32'hDEAD_BEEF; first_out = 32'hDEAD_BEEF;
        for (int i = 0; i < 14; i++) begin
            drive();
            if (req_valid && first_req === 32'hDEAD_BEEF) first_req = req_addr;
            if (out_valid) begin
                if (first_out === 32'hDEAD_BEEF) first_out = out_pc;
                vectors++; if (out_pc < 32'h8000_2000) begin miscompares++; $display("FAIL coin_wrong_path got=%h want>=80002000", out_pc); end
            end
            commit();
        end
        vectors++; if (first_req !== 32'h8000_2000) begin miscompares++; $display("FAIL coin_req_addr got=%h want=80002000", first_req); end
        vectors++; if (first_out !== 32'h8000_2000) begin miscompares++; $display("FAIL coin_first_out got=%h want=80002000", first_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first_req;
        do_reset();
        tb_req_ready = 1; tb_out_ready = 1; lat_max = 0;
        for (int i = 0; i < 4; i++) begin drive(); commit(); end
        tb_br = 1; tb_target = 32'h0000_0100;
        drive(); commit();
        tb_target = 32'h0000_0200;
        drive();
        vectors++; if (flush !== 1'b1 || req_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_cycle1 flush=%b req_valid=%b want=1/0", flush, req_valid); end
        commit();
        tb_br = 0;
        drive();
        vectors++; if (flush !== 1'b1 || req_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_cycle2 flush=%b req_valid=%b want=1/0", flush, req_valid); end
        commit();
        first_req = 32'hDEAD_BEEF;
        for (int i = 0; i < 10 && first_req === 32'hDEAD_BEEF; i++) begin
            drive();
            if (req_valid) first_req = req_addr;
            commit();
        end
        vectors++; if (first_req !== 32'h0000_0200) begin miscompares++; $display("FAIL b2b_req_addr got=%h want=00000200", first_req); end
    endtask

    task automatic test_wrap();
        logic [31:0] acc[$];
        bit          seen_top;
        tb_req_ready = 1; tb_out_ready = 1; lat_max = 0;
        tb_br = 1; tb_target = 32'hFFFF_FFFE;
        drive(); commit();
        tb_br = 0;
        seen_top = 0;
        for (int i = 0; i < 16; i++) begin
            drive();
            if (req_valid && req_ready) acc.push_back(req_addr);
            if (out_valid && out_pc === 32'hFFFF_FFFC && out_instr === mem_word(32'hFFFF_FFFC)) seen_top = 1;
            commit();
        end
        vectors++; if (acc.size() < 2) begin miscompares++; $display("FAIL wrap_count got=%0d want>=2", acc.size()); end
        if (acc.size() >= 2) begin
            vectors++; if (acc[0] !== 32'hFFFF_FFFC || acc[1] !== 32'h0) begin miscompares++; $display("FAIL wrap_addrs got=%h,%h want=fffffffc,00000000", acc[0], acc[1]); end
        end
        vectors++; if (!seen_top) begin miscompares++; $display("FAIL wrap_out got=0 want=1"); end
    endtask

    task automatic test_mid_reset();
        tb_out_ready = 1; lat_max = 2;
        for (int i = 0; i < 15; i++) begin
            tb_req_ready = ($urandom_range(0, 3) != 0);
            drive(); commit();
        end
        tb_req_ready = 1;
        tb_rst = 1;
        drive(); commit();
        tb_rst = 0;
        drive();
        vectors++; if (req_valid !== 1'b0 || out_valid !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL midrst_outputs got=%b/%b/%b want=0/0/0", req_valid, out_valid, flush); end
        commit();
        drive();
        vectors++; if (req_valid !== 1'b1 || req_addr !== RST_PC) begin miscompares++; $display("FAIL midrst_restart got=%b/%h want=1/%h", req_valid, req_addr, RST_PC); end
        commit();
    endtask

    task automatic test_random();
        logic [31:0] want_addr, want_pc, want_in;
        bit          want_ov;
        lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            tb_req_ready = ($urandom_range(0, 3) != 0);
            tb_out_ready = ($urandom_range(0, 2) != 0);
            tb_br        = ($urandom_range(0, 15) == 0);
            tb_target    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive();
            want_addr = exp_req_valid() ? exp_pc : 32'h0;
            want_ov   = exp_out.size() > 0;
            want_pc   = want_ov ? exp_out[0].pc  : 32'h0;
            want_in   = want_ov ? exp_out[0].ins : 32'h0;
            vectors++; if (req_valid !== exp_req_valid()) begin miscompares++; $display("FAIL rand_req_valid cyc=%0d got=%b want=%b", cyc, req_valid, exp_req_valid()); end
            vectors++; if (req_addr !== want_addr) begin miscompares++; $display("FAIL rand_req_addr cyc=%0d got=%h want=%h", cyc, req_addr, want_addr); end
            vectors++; if (out_valid !== want_ov) begin miscompares++; $display("FAIL rand_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, want_ov); end
            vectors++; if (out_pc !== want_pc || out_instr !== want_in) begin miscompares++; $display("FAIL rand_out cyc=%0d got=%h/%h want=%h/%h", cyc, out_pc, out_instr, want_pc, want_in); end
            vectors++; if (flush !== exp_flush) begin miscompares++; $display("FAIL rand_flush cyc=%0d got=%b want=%b", cyc, flush, exp_flush); end
            vectors++; if (int'(dut.w_pend_cnt) + int'(dut.w_out_cnt) > MAX) begin miscompares++; $display("FAIL rand_credit cyc=%0d got=%0d want<=%0d", cyc, int'(dut.w_pend_cnt) + int'(dut.w_out_cnt), MAX); end
            commit();
        end
        tb_br = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_pending();
        test_coincident();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
